uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmitter between several byte producers (security hazard

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin arbitration with an
// urgent override for requester 0, send/done handshake, inter-frame gap and a frame watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic                          urgent_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            err_o,
  output logic                          busy_o,
  output logic [15:0]                   frame_count_o,
  output logic                          tx_send_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_done_i
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W   = $clog2(GAP_EFF + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        r_owner;
  logic [WD_W-1:0]         r_wdog;
  logic [GAP_W-1:0]        r_gap;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_ack;
  logic [NUM_REQ-1:0]      r_err;
  logic [15:0]             r_count;
  logic                    r_send;
  logic [DATA_WIDTH-1:0]   r_data;

  logic [IDX_W-1:0]        w_win;
  logic [DATA_WIDTH-1:0]   w_slot;
  logic [WD_W-1:0]         w_wdog_nxt;
  logic [IDX_W-1:0]        w_rr_nxt;
  logic                    w_timeout;

  // Urgent requester 0 pre-empts; otherwise first set request scanning up from ptr, wrapping.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr,
                                                   input logic               urg);
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic [NUM_REQ-1:0] shifted;
    int                 idx;
    sel   = '0;
    found = urg & req[0];
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      shifted = req >> idx;
      if (!found && shifted[0]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign w_win      = pick_winner(req_i, r_rr_ptr, urgent_i);
  assign w_slot     = DATA_WIDTH'(req_data_i >> (int'(w_win) * DATA_WIDTH));
  assign w_wdog_nxt = r_wdog + WD_W'(1);
  assign w_timeout  = (w_wdog_nxt >= WD_W'(TIMEOUT_CYCLES - 1));
  assign w_rr_nxt   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_wdog   <= '0;
      r_gap    <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_count  <= '0;
      r_send   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_ack  <= '0;
      r_err  <= '0;
      r_send <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_i) begin
            r_owner <= w_win;
            r_grant <= onehot(w_win);
            r_data  <= w_slot;
            r_send  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a coincident watchdog expiry.
          if (tx_done_i || w_timeout) begin
            if (tx_done_i) begin
              r_ack   <= onehot(r_owner);
              r_count <= sat_inc16(r_count);
            end else begin
              r_err <= onehot(r_owner);
            end
            r_grant  <= '0;
            r_rr_ptr <= w_rr_nxt;
            r_gap    <= '0;
            r_state  <= S_GAP;
          end else begin
            r_wdog <= w_wdog_nxt;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_W'(GAP_EFF - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign ack_o         = r_ack;
  assign err_o         = r_err;
  assign busy_o        = (r_state != S_IDLE);
  assign frame_count_o = r_count;
  assign tx_send_o     = r_send;
  assign tx_data_o     = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected grants queued at stimulus time and
// checked against each tx_send_o pulse; handshake timing checked cycle-exactly.
module tb_uart_tx_arbiter;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int TO  = 50;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] req_data_i;
  logic            urgent_i;
  logic [N-1:0]    grant_o;
  logic [N-1:0]    ack_o;
  logic [N-1:0]    err_o;
  logic            busy_o;
  logic [15:0]     frame_count_o;
  logic            tx_send_o;
  logic [DW-1:0]   tx_data_o;
  logic            tx_done_i;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_data_i(req_data_i),
    .urgent_i(urgent_i), .grant_o(grant_o), .ack_o(ack_o), .err_o(err_o),
    .busy_o(busy_o), .frame_count_o(frame_count_o), .tx_send_o(tx_send_o),
    .tx_data_o(tx_data_o), .tx_done_i(tx_done_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   cur_owner;
  int   t_send;
  int   t_prev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int o, input logic [DW-1:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the next send pulse and score it against the queued expectation.
  task automatic take_send(input string tag);
    int   w;
    exp_t e;
    w = 0;
    while (tx_send_o !== 1'b1 && w < 100) begin
      tick(1);
      w++;
    end
    chk({tag, "_send_seen"}, {31'd0, tx_send_o}, 32'd1);
    t_send = cyc;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      cur_owner = e.owner;
      chk({tag, "_grant"}, {29'd0, grant_o}, {29'd0, oh(e.owner)});
      chk({tag, "_data"},  {24'd0, tx_data_o}, {24'd0, e.data});
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (busy_o !== 1'b0 && w < 200) begin
      tick(1);
      w++;
    end
    chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic done_now_and_ack(input string tag);
    tick(1);
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    chk({tag, "_ack"}, {29'd0, ack_o}, {29'd0, oh(cur_owner)});
    chk({tag, "_err"}, {29'd0, err_o}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_i      = '0;
    req_data_i = {8'h33, 8'hA5, 8'h11};
    urgent_i   = 1'b0;
    tx_done_i  = 1'b0;
    tick(2);

    // Reset state
    chk("rst_grant", {29'd0, grant_o}, 32'd0);
    chk("rst_ack",   {29'd0, ack_o}, 32'd0);
    chk("rst_err",   {29'd0, err_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_count", {16'd0, frame_count_o}, 32'd0);
    chk("rst_send",  {31'd0, tx_send_o}, 32'd0);
    chk("rst_data",  {24'd0, tx_data_o}, 32'd0);
    reset = 1'b0;
    tick(1);

    // Single request, done 10 cycles after send
    req_i = 3'b010;
    push_exp(1, 8'hA5);
    tick(1);
    chk("t1_latency", {31'd0, tx_send_o}, 32'd1);
    take_send("t1");
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    req_i = 3'b000;
    req_data_i = {8'h33, 8'h5A, 8'h11};
    tick(1);
    chk("t1_send_pulse", {31'd0, tx_send_o}, 32'd0);
    tick(9);
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    chk("t1_ack",   {29'd0, ack_o}, 32'b010);
    chk("t1_err",   {29'd0, err_o}, 32'd0);
    chk("t1_count", {16'd0, frame_count_o}, 32'd1);
    chk("t1_hold",  {24'd0, tx_data_o}, 32'hA5);
    chk("t1_ungrant", {29'd0, grant_o}, 32'd0);
    tick(1);
    chk("t1_ack_pulse", {29'd0, ack_o}, 32'd0);
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    tick(1);
    chk("gap_done_ack",   {29'd0, ack_o}, 32'd0);
    chk("gap_done_count", {16'd0, frame_count_o}, 32'd1);
    wait_idle("t1");

    // Round-robin from rr_ptr=0 with all requesters held
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req_data_i = {8'h33, 8'hC3, 8'h11};
    req_i = 3'b111;
    push_exp(0, 8'h11);
    push_exp(1, 8'hC3);
    push_exp(2, 8'h33);
    push_exp(0, 8'h11);
    t_prev = -1;
    for (int k = 0; k < 4; k++) begin
      take_send("t2");
      if (t_prev >= 0) chk("t2_spacing", t_send - t_prev, 3 + GAP);
      t_prev = t_send;
      done_now_and_ack("t2");
      if (k == 3) req_i = 3'b000;
    end
    chk("t2_count", {16'd0, frame_count_o}, 32'd4);
    wait_idle("t2");

    // Urgent override with rr_ptr=1
    urgent_i = 1'b1;
    req_i = 3'b011;
    push_exp(0, 8'h11);
    take_send("t3a");
    done_now_and_ack("t3a");
    req_i = 3'b010;
    push_exp(1, 8'hC3);
    take_send("t3b");
    done_now_and_ack("t3b");
    req_i = 3'b000;
    urgent_i = 1'b0;
    wait_idle("t3");

    // Watchdog timeout on requester 2
    req_i = 3'b100;
    push_exp(2, 8'h33);
    take_send("t4");
    req_i = 3'b000;
    tick(TO - 1);
    chk("t4_early_err", {29'd0, err_o}, 32'd0);
    tick(1);
    chk("t4_err",   {29'd0, err_o}, 32'b100);
    chk("t4_ack",   {29'd0, ack_o}, 32'd0);
    chk("t4_count", {16'd0, frame_count_o}, 32'd6);
    tick(1);
    chk("t4_err_pulse", {29'd0, err_o}, 32'd0);
    wait_idle("t4");
    req_i = 3'b111;
    push_exp(0, 8'h11);
    take_send("t4_rr");
    req_i = 3'b000;
    done_now_and_ack("t4_rr");
    wait_idle("t4_rr");

    // Done on the final watchdog cycle: ack wins
    req_i = 3'b010;
    push_exp(1, 8'hC3);
    take_send("t6");
    req_i = 3'b000;
    tick(TO - 1);
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    chk("t6_ack",   {29'd0, ack_o}, 32'b010);
    chk("t6_err",   {29'd0, err_o}, 32'd0);
    chk("t6_count", {16'd0, frame_count_o}, 32'd8);
    tick(1);
    chk("t6_err_late", {29'd0, err_o}, 32'd0);
    wait_idle("t6");

    // Reset mid-WAIT, stale done afterwards
    req_i = 3'b001;
    push_exp(0, 8'h11);
    take_send("t5");
    tick(3);
    reset = 1'b1;
    req_i = 3'b000;
    tick(1);
    reset = 1'b0;
    chk("t5_grant", {29'd0, grant_o}, 32'd0);
    chk("t5_busy",  {31'd0, busy_o}, 32'd0);
    chk("t5_count", {16'd0, frame_count_o}, 32'd0);
    chk("t5_data",  {24'd0, tx_data_o}, 32'd0);
    tick(1);
    tx_done_i = 1'b1;
    tick(1);
    tx_done_i = 1'b0;
    chk("t5_stale_ack", {29'd0, ack_o}, 32'd0);
    chk("t5_stale_err", {29'd0, err_o}, 32'd0);
    chk("t5_stale_count", {16'd0, frame_count_o}, 32'd0);
    req_i = 3'b111;
    push_exp(0, 8'h11);
    take_send("t5_next");
    req_i = 3'b000;
    done_now_and_ack("t5_next");
    chk("t5_count_after", {16'd0, frame_count_o}, 32'd1);
    wait_idle("t5_next");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
